uart_boot_loader: RTL and testbench

- Controller that sequences the UART receiver's byte stream into a framed program-load protocol and issues 32-bit memory writes to instruction/data RAM.
- Holds the rv32 core in reset while loading and releases it only after a frame with a valid checksum completes.
- Sits between the UART receiver output (8-bit byte plus ready flag) and the memory write port shared with the core.

---
 rtl/uart_boot_loader.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//   Turns the UART receiver byte stream into a framed program load and issues
//   32-bit word writes to the shared instruction/data RAM. The rv32 core is
//   held in reset while a frame is loading. It is released only when a frame
//   ends with a valid checksum.
//
//   Frame: HEADER_BYTE, addr[4] (LE), len[2] (LE, words), len*4 data (LE), csum.
//   The 8-bit sum of every byte after the header, including csum, must be 0.
//
// Ports
//   clk              system clock
//   reset            asynchronous, active-high
//   rx_data_i        received byte
//   rx_valid_i       receiver ready flag (a byte is counted on its rising edge)
//   mem_addr_o       word-aligned write address
//   mem_wdata_o      write data
//   mem_we_o         write request, held until mem_ready_i
//   mem_ready_i      memory accepts the write when high together with mem_we_o
//   cpu_reset_hold_o holds the core in reset
//   busy_o           high whenever the FSM is not idle
//   load_done_o      one-cycle pulse on a successful frame
//   load_error_o     sticky error flag, cleared by the next header byte
//   err_code_o       0 none, 1 checksum, 2 timeout, 3 overrun
//
// state  | meaning
// IDLE   | waiting for HEADER_BYTE, other bytes ignored
// ADDR   | collecting 4 address bytes
// LEN    | collecting 2 length bytes (word count)
// DATA   | collecting 4 bytes of the next word
// WRITE  | mem_we_o asserted, waiting for mem_ready_i
// CSUM   | waiting for the checksum byte
module uart_boot_loader #(
  parameter logic [7:0] HEADER_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 20_000_000,
  parameter int         TO_W           = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  input  logic        mem_ready_i,
  output logic        cpu_reset_hold_o,
  output logic        busy_o,
  output logic        load_done_o,
  output logic        load_error_o,
  output logic [1:0]  err_code_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_DATA, S_WRITE, S_CSUM
  } state_t;

  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  logic            rx_valid_q;
  logic [1:0]      cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     word_q, word_d;
  logic [15:0]     len_q, len_d;
  logic [7:0]      sum_q, sum_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            we_q, we_d;
  logic            hold_q, hold_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [1:0]      code_q, code_d;

  logic            rx_stb;
  logic            err_hit;
  logic [1:0]      err_val;

  assign rx_stb = rx_valid_i & ~rx_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rx_valid_q <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      len_q      <= '0;
      sum_q      <= '0;
      to_q       <= '0;
      we_q       <= 1'b0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      code_q     <= '0;
    end else begin
      state_q    <= state_d;
      rx_valid_q <= rx_valid_i;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      len_q      <= len_d;
      sum_q      <= sum_d;
      to_q       <= to_d;
      we_q       <= we_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
      code_q     <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    word_d  = word_q;
    len_d   = len_q;
    sum_d   = sum_q;
    to_d    = '0;
    we_d    = we_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    error_d = error_q;
    code_d  = code_q;
    err_hit = 1'b0;
    err_val = '0;

    // Inter-byte timer; a byte arriving on the expiry cycle takes priority.
    if (state_q != S_IDLE && state_q != S_WRITE && !rx_stb) begin
      if (to_q == TO_LAST) begin
        err_hit = 1'b1;
        err_val = ERR_TIMEOUT;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (rx_stb && rx_data_i == HEADER_BYTE) begin
          state_d = S_ADDR;
          hold_d  = 1'b1;
          error_d = 1'b0;
          code_d  = '0;
          sum_d   = '0;
          cnt_d   = '0;
          addr_d  = '0;
          len_d   = '0;
          word_d  = '0;
        end
      end
      S_ADDR: begin
        if (rx_stb) begin
          sum_d  = sum_q + rx_data_i;
          addr_d = {rx_data_i, addr_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            addr_d[1:0] = 2'b00;
            state_d     = S_LEN;
          end
        end
      end
      S_LEN: begin
        if (rx_stb) begin
          sum_d = sum_q + rx_data_i;
          len_d = {rx_data_i, len_q[15:8]};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd1) begin
            cnt_d   = '0;
            state_d = (len_d == 16'd0) ? S_CSUM : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_stb) begin
          sum_d  = sum_q + rx_data_i;
          word_d = {rx_data_i, word_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_WRITE;
            we_d    = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (mem_ready_i && we_q) begin
          we_d    = 1'b0;
          addr_d  = addr_q + 32'd4;
          len_d   = len_q - 16'd1;
          state_d = (len_d == 16'd0) ? S_CSUM : S_DATA;
        end
        // A byte arriving before the write drains is lost; the write itself
        // still completes if it was accepted on this same cycle.
        if (rx_stb) begin
          err_hit = 1'b1;
          err_val = ERR_OVERRUN;
        end
      end
      S_CSUM: begin
        if (rx_stb) begin
          sum_d = sum_q + rx_data_i;
          if (sum_d == 8'd0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            err_hit = 1'b1;
            err_val = ERR_CSUM;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (err_hit) begin
      state_d = S_IDLE;
      we_d    = 1'b0;
      hold_d  = 1'b1;
      error_d = 1'b1;
      code_d  = err_val;
      to_d    = '0;
    end
  end

  assign mem_addr_o       = addr_q;
  assign mem_wdata_o      = word_q;
  assign mem_we_o         = we_q;
  assign cpu_reset_hold_o = hold_q;
  assign busy_o           = (state_q != S_IDLE);
  assign load_done_o      = done_q;
  assign load_error_o     = error_q;
  assign err_code_o       = code_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Testbench for uart_boot_loader. Expected writes go into a scoreboard queue
// when a frame is built. They are compared against the memory port while
// mem_we_o is high and popped when the write is accepted.
module tb_uart_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_we_o, cpu_reset_hold_o, busy_o, load_done_o, load_error_o;
  logic [1:0]  err_code_o;

  uart_boot_loader #(.TIMEOUT_CYCLES(100)) dut (
    .clk              (clk),
    .reset            (reset),
    .rx_data_i        (rx_data_i),
    .rx_valid_i       (rx_valid_i),
    .mem_addr_o       (mem_addr_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_we_o         (mem_we_o),
    .mem_ready_i      (mem_ready_i),
    .cpu_reset_hold_o (cpu_reset_hold_o),
    .busy_o           (busy_o),
    .load_done_o      (load_done_o),
    .load_error_o     (load_error_o),
    .err_code_o       (err_code_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] frm[$];
  int checks = 0;
  int failures = 0;
  int hold_cyc = 1;
  int gap_cyc = 10;
  int ready_delay = 0;
  bit ready_block = 1'b0;
  int we_age = 0;
  int done_cnt = 0;
  int wr_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    repeat (hold_cyc) @(negedge clk);
    rx_valid_i = 1'b0;
    repeat (gap_cyc) @(negedge clk);
  endtask

  task automatic build(input logic [31:0] addr, input int n, input logic [31:0] w0,
                       input logic [31:0] w1, input bit bad);
    logic [7:0]  s;
    logic [31:0] w;
    logic [31:0] a;
    s = 8'h00;
    a = {addr[31:2], 2'b00};
    frm.delete();
    frm.push_back(8'hA5);
    for (int i = 0; i < 4; i++) begin
      frm.push_back(addr[8*i +: 8]);
      s = s + addr[8*i +: 8];
    end
    frm.push_back(8'(n));
    frm.push_back(8'(n >> 8));
    s = s + 8'(n) + 8'(n >> 8);
    for (int k = 0; k < n; k++) begin
      w = (k == 0) ? w0 : w1;
      for (int i = 0; i < 4; i++) begin
        frm.push_back(w[8*i +: 8]);
        s = s + w[8*i +: 8];
      end
      exp_q.push_back('{a: a + 32'(4 * k), d: w});
    end
    frm.push_back(8'h00 - s + (bad ? 8'h01 : 8'h00));
  endtask

  task automatic send_frame();
    for (int i = 0; i < frm.size(); i++) send_byte(frm[i]);
  endtask

  // Memory side: compare the pending write every cycle it is requested,
  // assert mem_ready_i after ready_delay cycles, pop on acceptance.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_we_o) begin
        if (exp_q.size() == 0) begin
          check("unexp_wr", {31'b0, mem_we_o}, 32'd0);
        end else begin
          check("wr_addr", mem_addr_o, exp_q[0].a);
          check("wr_data", mem_wdata_o, exp_q[0].d);
        end
        if (!ready_block && we_age >= ready_delay) begin
          mem_ready_i = 1'b1;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          wr_cnt++;
        end else begin
          mem_ready_i = 1'b0;
        end
        we_age++;
      end else begin
        mem_ready_i = 1'b0;
        we_age = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (load_done_o) done_cnt++;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int w0;
    int n;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_hold", {31'b0, cpu_reset_hold_o}, 32'd1);
    check("rst_we", {31'b0, mem_we_o}, 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_wdata", mem_wdata_o, 32'd0);
    check("rst_err", {29'b0, load_error_o, err_code_o}, 32'd0);
    check("rst_done", {31'b0, load_done_o}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // good single word
    d0 = done_cnt; w0 = wr_cnt;
    build(32'h0000_0100, 1, 32'hDEAD_BEEF, 32'h0, 1'b0);
    send_frame();
    check("s1_done", 32'(done_cnt - d0), 32'd1);
    check("s1_writes", 32'(wr_cnt - w0), 32'd1);
    check("s1_hold", {31'b0, cpu_reset_hold_o}, 32'd0);
    check("s1_err", {31'b0, load_error_o}, 32'd0);
    check("s1_busy", {31'b0, busy_o}, 32'd0);
    check("s1_q", 32'(exp_q.size()), 32'd0);

    // two words across a 4 KiB boundary, slow memory
    ready_delay = 5;
    d0 = done_cnt; w0 = wr_cnt;
    build(32'h0000_0FFC, 2, 32'h1122_3344, 32'hCAFE_F00D, 1'b0);
    send_frame();
    check("s2_done", 32'(done_cnt - d0), 32'd1);
    check("s2_writes", 32'(wr_cnt - w0), 32'd2);
    check("s2_q", 32'(exp_q.size()), 32'd0);
    ready_delay = 0;

    // bad checksum: the write still happens
    d0 = done_cnt; w0 = wr_cnt;
    build(32'h0000_0100, 1, 32'hDEAD_BEEF, 32'h0, 1'b1);
    send_frame();
    check("s3_done", 32'(done_cnt - d0), 32'd0);
    check("s3_writes", 32'(wr_cnt - w0), 32'd1);
    check("s3_err", {31'b0, load_error_o}, 32'd1);
    check("s3_code", {30'b0, err_code_o}, 32'd1);
    check("s3_hold", {31'b0, cpu_reset_hold_o}, 32'd1);

    // timeout after A5 00 01
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    n = 0;
    while (!load_error_o && n < 150) begin
      @(negedge clk);
      n++;
    end
    check("s4_to_err", {31'b0, load_error_o}, 32'd1);
    check("s4_to_time", {31'b0, (n >= 85 && n <= 95)}, 32'd1);
    check("s4_code", {30'b0, err_code_o}, 32'd2);
    check("s4_busy", {31'b0, busy_o}, 32'd0);
    d0 = done_cnt;
    build(32'h0000_0400, 1, 32'h0BAD_F00D, 32'h0, 1'b0);
    send_byte(frm[0]);
    check("s4_clr_err", {29'b0, load_error_o, err_code_o}, 32'd0);
    check("s4_busy_hdr", {31'b0, busy_o}, 32'd1);
    for (int i = 1; i < frm.size(); i++) send_byte(frm[i]);
    check("s4_done", 32'(done_cnt - d0), 32'd1);
    check("s4_hold", {31'b0, cpu_reset_hold_o}, 32'd0);
    check("s4_q", 32'(exp_q.size()), 32'd0);

    // overrun: next byte lands while the write is still pending
    ready_block = 1'b1;
    build(32'h0000_0200, 2, 32'hAAAA_5555, 32'h1234_5678, 1'b0);
    for (int i = 0; i < 11; i++) send_byte(frm[i]);
    check("s5_we_held", {31'b0, mem_we_o}, 32'd1);
    @(negedge clk);
    rx_data_i  = frm[11];
    rx_valid_i = 1'b1;
    @(posedge clk);
    #1;
    check("s5_we_drop", {31'b0, mem_we_o}, 32'd0);
    check("s5_err", {31'b0, load_error_o}, 32'd1);
    check("s5_code", {30'b0, err_code_o}, 32'd3);
    check("s5_busy", {31'b0, busy_o}, 32'd0);
    @(negedge clk);
    rx_valid_i = 1'b0;
    exp_q.delete();
    ready_block = 1'b0;
    repeat (3) @(negedge clk);

    // rx_valid held high for 10 cycles per byte
    hold_cyc = 10;
    d0 = done_cnt; w0 = wr_cnt;
    build(32'h0000_0300, 1, 32'h8765_4321, 32'h0, 1'b0);
    send_frame();
    check("s6_done", 32'(done_cnt - d0), 32'd1);
    check("s6_writes", 32'(wr_cnt - w0), 32'd1);
    check("s6_err", {31'b0, load_error_o}, 32'd0);
    hold_cyc = 1;

    // len = 0: no writes, still a successful load
    d0 = done_cnt; w0 = wr_cnt;
    build(32'h0000_0000, 0, 32'h0, 32'h0, 1'b0);
    send_frame();
    check("s7_done", 32'(done_cnt - d0), 32'd1);
    check("s7_writes", 32'(wr_cnt - w0), 32'd0);
    check("s7_hold", {31'b0, cpu_reset_hold_o}, 32'd0);

    // async reset in the middle of DATA
    build(32'h0000_0100, 1, 32'hDEAD_BEEF, 32'h0, 1'b0);
    for (int i = 0; i < 9; i++) send_byte(frm[i]);
    check("s8_busy_pre", {31'b0, busy_o}, 32'd1);
    check("s8_addr_pre", mem_addr_o, 32'h0000_0100);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("s8_busy", {31'b0, busy_o}, 32'd0);
    check("s8_addr", mem_addr_o, 32'd0);
    check("s8_wdata", mem_wdata_o, 32'd0);
    check("s8_we", {31'b0, mem_we_o}, 32'd0);
    check("s8_hold", {31'b0, cpu_reset_hold_o}, 32'd1);
    check("s8_err", {29'b0, load_error_o, err_code_o}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    d0 = done_cnt;
    build(32'h0000_0000, 0, 32'h0, 32'h0, 1'b0);
    send_frame();
    check("s8_recover", 32'(done_cnt - d0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
